sram_arbiter: RTL and testbench
===============================

# sram_arbiter

Shares the board's single 16-bit asynchronous SRAM between two requesters in the audio path: port 0 (recorder, write-mostly) and port 1 (DSP/player, read-mostly). Sits between those blocks and the SRAM pins inside the top-level audio core, clocked by the 12 MHz audio clock. Performs round-robin arbitration, sequences each access with a fixed multi-cycle SRAM cycle, and returns a one-cycle acknowledge with read data.

## Interface
- ACCESS_CYCLES, 2: cycles the SRAM bus is held per access; legal values are 2 or more.
- ADDR_W, 20: SRAM word-address width.
- DATA_W, 16: SRAM data width.

Ports:
- i_clk  in  1  audio clock; the only clock.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_req[1:0]  in  2  per-port request level.
- i_we[1:0]  in  2  per-port write enable: 1 = write, 0 = read.
- i_addr0, i_addr1  in  ADDR_W  per-port address.
- i_wdata0, i_wdata1  in  DATA_W  per-port write data.
- o_ack[1:0]  out  2  one-cycle completion pulse per port.
- o_rdata  out  DATA_W  read data; valid while the matching o_ack bit is high.
- o_busy  out  1  high in ACCESS and ACK.
- o_SRAM_ADDR  out  ADDR_W  SRAM address.
- io_SRAM_DQ  inout  DATA_W  SRAM data bus.
- o_SRAM_WE_N, o_SRAM_CE_N, o_SRAM_OE_N, o_SRAM_LB_N, o_SRAM_UB_N  out  1 each  SRAM strobes, active low.

## Operation
- FSM states: IDLE, ACCESS, ACK.
- IDLE:
  - i_req is sampled only in this state.
  - If any request is pending: choose a winner, latch its addr, we and wdata into internal registers, clear the cycle counter, and go to ACCESS.
- Arbitration:
  - A single requester wins.
  - If both request, the winner is the port not granted last.
  - last_grant resets to 1, so port 0 wins the first collision.
- ACCESS lasts exactly ACCESS_CYCLES cycles, then moves to ACK.
  - CE_N, LB_N and UB_N are 0 throughout.
  - Read: OE_N = 0 throughout. DQ is sampled into the o_rdata register at the clock edge that ends the last ACCESS cycle.
  - Write: OE_N = 1. DQ is driven with the latched wdata throughout. WE_N = 1 in the first ACCESS cycle (address setup) and 0 in the remaining cycles.
- ACK:
  - o_ack[winner] = 1 for one cycle and the bus is idle.
  - last_grant is updated to the winner.
  - Next state is IDLE.
- Outside ACCESS:
  - All strobes are 1 and DQ is high-Z.
  - o_SRAM_ADDR holds its last value.
- Requester contract:
  - Hold req, we, addr and wdata stable until ack is seen.
  - To avoid a repeat access, req must be low in the cycle after ack.
- o_rdata holds its value until the next read completes. Writes leave it unchanged.

## Timing
- Reset values, applied immediately and asynchronously:
  - State IDLE, o_ack = 0, o_rdata = 0, o_busy = 0.
  - o_SRAM_ADDR = 0; all SRAM strobes = 1; DQ high-Z.
  - last_grant = 1.
- Reset mid-access: the access is abandoned with no ack, and every output returns to its reset value.
- Latency: if a request is sampled in IDLE at edge k, ACCESS occupies cycles k+1 through k+N and ack occurs in cycle k+N+1. N = ACCESS_CYCLES.
- Throughput: one access per N+2 cycles.
- Back-to-back collision:
  - Port 0 is served, and port 1 is acked N+2 cycles later.
  - Ports then alternate while both keep requesting.
- A request that rises during ACCESS or ACK waits for the next IDLE.
- A request that drops before being sampled is never served.
- All outputs are registered. io_SRAM_DQ is driven from the registered write-enable and data.

## Structure
- Package sram_arb_pkg holds:
  - the state enum (S_IDLE, S_ACCESS, S_ACK);
  - ADDR_W and DATA_W constants;
  - the port-index localparams.
- Single module; no sub-module. The round-robin pick is a small combinational function inside the module.

## Test plan
- Reset then idle: all strobes 1, DQ = Z, o_ack = 0, o_rdata = 0, o_busy = 0.
- Port 0 writes 16'hA5A5 to addr 20'h00010 (N = 2):
  - CE_N = 0 for 2 cycles;
  - WE_N = 0 only in the 2nd cycle;
  - o_ack[0] pulses 3 cycles after the request is sampled.
- Port 1 reads addr 20'h00010 with the SRAM model returning 16'hA5A5: OE_N = 0 for 2 cycles, then o_ack[1] = 1 with o_rdata = 16'hA5A5.
- Both ports request continuously:
  - grant order is 0, 1, 0, 1;
  - acks are spaced 4 cycles apart;
  - no port is starved.
- Reset asserted in the 1st ACCESS cycle of a write:
  - strobes go to 1 and DQ to Z immediately;
  - no ack;
  - a later port-0 request is served normally.
- ACCESS_CYCLES = 4: a read ack arrives 5 cycles after sampling, and WE_N is low for exactly 3 cycles on a write.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// rtl/sram_arb_pkg.sv - shared types and constants for the two-port SRAM arbiter
// Contents: FSM state enum, default SRAM address/data widths, requester port indices.
package sram_arb_pkg;

  localparam int ADDR_W = 20;
  localparam int DATA_W = 16;

  // Requester port indices into i_req / i_we / o_ack.
  localparam int PORT_REC = 0;  // recorder, write-mostly
  localparam int PORT_DSP = 1;  // DSP/player, read-mostly

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_ACK    = 2'd2
  } state_e;

endpackage

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - round-robin two-port arbiter and sequencer for the asynchronous audio SRAM
// Ports:
//   i_clk, i_rst_n            audio clock, asynchronous active-low reset
//   i_req, i_we               per-port request level and write enable (1 = write)
//   i_addr0/1, i_wdata0/1     per-port address and write data, held until ack
//   o_ack                     one-cycle completion pulse per port
//   o_rdata                   last completed read data
//   o_busy                    high while an access or its ack is in progress
//   o_SRAM_*, io_SRAM_DQ      SRAM pins, strobes active low, all registered
module sram_arbiter #(
  parameter int ACCESS_CYCLES = 2,
  parameter int ADDR_W        = sram_arb_pkg::ADDR_W,
  parameter int DATA_W        = sram_arb_pkg::DATA_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [1:0]        i_req,
  input  logic [1:0]        i_we,
  input  logic [ADDR_W-1:0] i_addr0,
  input  logic [ADDR_W-1:0] i_addr1,
  input  logic [DATA_W-1:0] i_wdata0,
  input  logic [DATA_W-1:0] i_wdata1,
  output logic [1:0]        o_ack,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_busy,
  output logic [ADDR_W-1:0] o_SRAM_ADDR,
  inout  wire  [DATA_W-1:0] io_SRAM_DQ,
  output logic              o_SRAM_WE_N,
  output logic              o_SRAM_CE_N,
  output logic              o_SRAM_OE_N,
  output logic              o_SRAM_LB_N,
  output logic              o_SRAM_UB_N
);
  import sram_arb_pkg::*;

  localparam int              CNT_W    = $clog2(ACCESS_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCESS_CYCLES - 1);

  // Round-robin pick: a lone requester wins; on a collision the port not
  // granted last time wins.
  function automatic logic pick_port(input logic [1:0] req, input logic last);
    if (req == 2'b11) return ~last;
    return req[PORT_REC] ? 1'(PORT_REC) : 1'(PORT_DSP);
  endfunction

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              last_q, last_d;
  logic              win_q, win_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        ack_q, ack_d;
  logic              busy_q, busy_d;
  logic              ce_n_q, ce_n_d;
  logic              oe_n_q, oe_n_d;
  logic              we_n_q, we_n_d;
  logic              dq_oe_q, dq_oe_d;
  logic              in_access;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    win_d   = win_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    ack_d   = '0;

    unique case (state_q)
      S_IDLE: begin
        if (|i_req) begin
          win_d   = pick_port(i_req, last_q);
          we_d    = i_we[win_d];
          addr_d  = (win_d == 1'(PORT_DSP)) ? i_addr1  : i_addr0;
          wdata_d = (win_d == 1'(PORT_DSP)) ? i_wdata1 : i_wdata0;
          cnt_d   = '0;
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (cnt_q == CNT_LAST) begin
          state_d       = S_ACK;
          ack_d[win_q]  = 1'b1;
          last_d        = win_q;
          // The SRAM has had the full access window to settle by this edge.
          if (!we_q) rdata_d = io_SRAM_DQ;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Pin values are computed from the state being entered so the registered
    // strobes line up exactly with the ACCESS cycles.
    in_access = (state_d == S_ACCESS);
    ce_n_d    = ~in_access;
    oe_n_d    = ~(in_access && !we_d);
    // First write cycle keeps WE_N high as address setup.
    we_n_d    = ~(in_access && we_d && (cnt_d != '0));
    dq_oe_d   = in_access && we_d;
    busy_d    = (state_d != S_IDLE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      last_q  <= 1'(PORT_DSP);
      win_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ack_q   <= '0;
      busy_q  <= 1'b0;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      dq_oe_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      win_q   <= win_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      ce_n_q  <= ce_n_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
      dq_oe_q <= dq_oe_d;
    end
  end

  assign io_SRAM_DQ  = dq_oe_q ? wdata_q : {DATA_W{1'bz}};
  assign o_ack       = ack_q;
  assign o_rdata     = rdata_q;
  assign o_busy      = busy_q;
  assign o_SRAM_ADDR = addr_q;
  assign o_SRAM_WE_N = we_n_q;
  assign o_SRAM_CE_N = ce_n_q;
  assign o_SRAM_OE_N = oe_n_q;
  assign o_SRAM_LB_N = ce_n_q;
  assign o_SRAM_UB_N = ce_n_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - model-checked randomized bench for sram_arbiter at ACCESS_CYCLES 2 and 4
`timescale 1ns/1ps
module tb_sram_arbiter;
  localparam int AW = 20;
  localparam int DW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input int id, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL n%0d %s: got %0h expected %0h at %0t", id, name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : inst
    localparam int N        = (g == 0) ? 2 : 4;
    // Hand-derived timing for each configuration.
    localparam int LAT      = (g == 0) ? 3 : 5;
    localparam int CE_LOW   = (g == 0) ? 2 : 4;
    localparam int WE_LOW   = (g == 0) ? 1 : 3;
    localparam int SPACING  = (g == 0) ? 4 : 6;

    logic          rst_n  = 1'b0;
    logic [1:0]    req    = '0;
    logic [1:0]    we     = '0;
    logic [AW-1:0] addr0  = '0;
    logic [AW-1:0] addr1  = '0;
    logic [DW-1:0] wdata0 = '0;
    logic [DW-1:0] wdata1 = '0;
    logic [1:0]    ack;
    logic [DW-1:0] rdata;
    logic          busy;
    logic [AW-1:0] sram_addr;
    wire  [DW-1:0] dq;
    logic          we_n, ce_n, oe_n, lb_n, ub_n;
    logic          fin = 1'b0;
    logic [DW-1:0] mem [256];

    sram_arbiter #(.ACCESS_CYCLES(N), .ADDR_W(AW), .DATA_W(DW)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_we(we),
      .i_addr0(addr0), .i_addr1(addr1), .i_wdata0(wdata0), .i_wdata1(wdata1),
      .o_ack(ack), .o_rdata(rdata), .o_busy(busy), .o_SRAM_ADDR(sram_addr),
      .io_SRAM_DQ(dq), .o_SRAM_WE_N(we_n), .o_SRAM_CE_N(ce_n), .o_SRAM_OE_N(oe_n),
      .o_SRAM_LB_N(lb_n), .o_SRAM_UB_N(ub_n)
    );

    // Asynchronous SRAM device, 256 words decoded from the low address byte.
    assign dq = (!ce_n && !oe_n && we_n) ? mem[sram_addr[7:0]] : 16'hzzzz;
    initial begin
      for (int i = 0; i < 256; i++) mem[i] = 16'(i * 257) ^ 16'h3C5A;
      forever begin
        @(posedge clk);
        if (!ce_n && !we_n) mem[sram_addr[7:0]] = dq;
      end
    end

    // Transaction-level model: each sampled request occupies a timeline
    // slot; phase = cycles since sampling, ACCESS for 0..N-1, ack at N.
    int            cyc = 0;
    int            t_start = 0;
    logic          act = 1'b0;
    logic          last = 1'b1;
    logic          win = 1'b0;
    logic          twe = 1'b0;
    logic [AW-1:0] taddr = '0;
    logic [DW-1:0] twd = '0;
    logic [DW-1:0] exp_rdata = '0;
    logic [DW-1:0] ref_mem [256];

    function automatic int phase();
      if (act && (cyc - t_start) <= N) return cyc - t_start;
      return -1;
    endfunction

    initial begin
      for (int i = 0; i < 256; i++) ref_mem[i] = 16'(i * 257) ^ 16'h3C5A;
      forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
          cyc = 0; act = 1'b0; last = 1'b1; taddr = '0; exp_rdata = '0;
        end else begin
          cyc++;
          if (act && (cyc - t_start) == N) begin
            last = win;
            if (twe) ref_mem[taddr[7:0]] = twd;
            else     exp_rdata = ref_mem[taddr[7:0]];
          end
          if ((!act || (cyc - t_start) >= N + 2) && req != 2'b00) begin
            win     = (req == 2'b11) ? ~last : req[1];
            twe     = we[win];
            taddr   = win ? addr1 : addr0;
            twd     = win ? wdata1 : wdata0;
            t_start = cyc;
            act     = 1'b1;
          end
        end
      end
    end

    // Every-cycle comparison of all outputs against the model.
    initial begin
      int   ph;
      logic in_acc;
      logic dqz;
      forever begin
        @(negedge clk);
        ph     = phase();
        in_acc = (ph >= 0) && (ph < N);
        dqz    = (dq === 16'hzzzz);
        check(g, "ack",   32'(ack),       (ph == N) ? (32'd1 << win) : 32'd0);
        check(g, "busy",  32'(busy),      32'(ph >= 0));
        check(g, "rdata", 32'(rdata),     32'(exp_rdata));
        check(g, "addr",  32'(sram_addr), 32'(taddr));
        check(g, "ce_n",  32'(ce_n),      32'(!in_acc));
        check(g, "lb_n",  32'(lb_n),      32'(!in_acc));
        check(g, "ub_n",  32'(ub_n),      32'(!in_acc));
        check(g, "oe_n",  32'(oe_n),      32'(!(in_acc && !twe)));
        check(g, "we_n",  32'(we_n),      32'(!(in_acc && twe && ph >= 1)));
        if (in_acc && twe) check(g, "dq_wr", 32'(dq), 32'(twd));
        else if (!in_acc)  check(g, "dq_z", 32'(dqz), 32'd1);
      end
    end

    task automatic do_access(input int p, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                             output int o_ce, output int o_we, output int o_oe, output int o_lat,
                             output logic [DW-1:0] o_rd);
      o_ce = 0; o_we = 0; o_oe = 0; o_lat = -1; o_rd = '0;
      @(negedge clk);
      req[p] = 1'b1;
      we[p]  = w;
      if (p == 0) begin addr0 = a; wdata0 = d; end
      else        begin addr1 = a; wdata1 = d; end
      for (int t = 1; t <= 40; t++) begin
        @(negedge clk);
        if (!ce_n) o_ce++;
        if (!we_n) o_we++;
        if (!oe_n) o_oe++;
        if (ack[p]) begin
          o_lat = t; o_rd = rdata; req[p] = 1'b0;
          break;
        end
      end
      req[p] = 1'b0;
      @(negedge clk);
    endtask

    initial begin
      int            n_ce, n_we, n_oe, n_lat, n_acks, tt, pp;
      int            order [4];
      int            at [4];
      int            rr [2];
      int            cool [2];
      logic [DW-1:0] rd_v;
      logic          dqz;

      // Reset state.
      repeat (2) @(negedge clk);
      dqz = (dq === 16'hzzzz);
      check(g, "rst ce_n",  32'(ce_n),  32'd1);
      check(g, "rst oe_n",  32'(oe_n),  32'd1);
      check(g, "rst we_n",  32'(we_n),  32'd1);
      check(g, "rst dq_z",  32'(dqz),   32'd1);
      check(g, "rst ack",   32'(ack),   32'd0);
      check(g, "rst rdata", 32'(rdata), 32'd0);
      check(g, "rst busy",  32'(busy),  32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Port 0 writes A5A5 to 0x00010.
      do_access(0, 1'b1, 20'h00010, 16'hA5A5, n_ce, n_we, n_oe, n_lat, rd_v);
      check(g, "wr ce_low", 32'(n_ce),  32'(CE_LOW));
      check(g, "wr we_low", 32'(n_we),  32'(WE_LOW));
      check(g, "wr lat",    32'(n_lat), 32'(LAT));

      // Port 1 reads it back.
      do_access(1, 1'b0, 20'h00010, 16'h0000, n_ce, n_we, n_oe, n_lat, rd_v);
      check(g, "rd oe_low", 32'(n_oe),  32'(CE_LOW));
      check(g, "rd lat",    32'(n_lat), 32'(LAT));
      check(g, "rd data",   32'(rd_v),  32'h0000A5A5);

      // Both ports keep requesting: port 0 writes 1234 to 0x20, port 1 reads 0x20.
      @(negedge clk);
      addr0 = 20'h00020; wdata0 = 16'h1234; addr1 = 20'h00020;
      we = 2'b01; req = 2'b11;
      n_acks = 0; tt = 0; rr[0] = 0; rr[1] = 0;
      for (int i = 0; i < 4; i++) begin order[i] = 3; at[i] = 0; end
      while (n_acks < 4 && tt < 80) begin
        @(negedge clk);
        tt++;
        for (int p = 0; p < 2; p++) begin
          if (rr[p] > 0) begin
            rr[p]--;
            if (rr[p] == 0) req[p] = 1'b1;
          end
        end
        if (ack != 2'b00) begin
          pp = ack[1] ? 1 : 0;
          order[n_acks] = pp; at[n_acks] = tt; n_acks++;
          req[pp] = 1'b0; rr[pp] = 2;
        end
      end
      req = 2'b00;
      for (int i = 0; i < 4; i++) check(g, "rr order", 32'(order[i]), 32'(i % 2));
      for (int i = 1; i < 4; i++) check(g, "rr spacing", 32'(at[i] - at[i-1]), 32'(SPACING));
      repeat (3) @(negedge clk);

      // Reset during the first ACCESS cycle of a write to 0x30.
      req[0] = 1'b1; we[0] = 1'b1; addr0 = 20'h00030; wdata0 = 16'hBEEF;
      @(posedge clk);
      #1;
      check(g, "mid started", 32'(ce_n), 32'd0);
      #1;
      rst_n = 1'b0;
      #1;
      dqz = (dq === 16'hzzzz);
      check(g, "mid ce_n",  32'(ce_n),      32'd1);
      check(g, "mid oe_n",  32'(oe_n),      32'd1);
      check(g, "mid we_n",  32'(we_n),      32'd1);
      check(g, "mid dq_z",  32'(dqz),       32'd1);
      check(g, "mid busy",  32'(busy),      32'd0);
      check(g, "mid rdata", 32'(rdata),     32'd0);
      check(g, "mid addr",  32'(sram_addr), 32'd0);
      @(negedge clk);
      req = 2'b00;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      // The abandoned write must not have reached the SRAM.
      do_access(0, 1'b0, 20'h00030, 16'h0000, n_ce, n_we, n_oe, n_lat, rd_v);
      check(g, "post lat",  32'(n_lat), 32'(LAT));
      check(g, "post data", 32'(rd_v),  32'h00000C6A);
      do_access(0, 1'b0, 20'h00010, 16'h0000, n_ce, n_we, n_oe, n_lat, rd_v);
      check(g, "post keep", 32'(rd_v),  32'h0000A5A5);

      // Random traffic obeying the requester contract, with occasional
      // withdrawal of requests not yet sampled.
      cool[0] = 0; cool[1] = 0;
      for (int c = 0; c < 700; c++) begin
        @(posedge clk);
        #2;
        for (int p = 0; p < 2; p++) begin
          if (cool[p] > 0) begin
            cool[p]--;
          end else if (req[p]) begin
            if (phase() == N && win == 1'(p)) begin
              req[p] = 1'b0; cool[p] = 2;
            end else if (!(phase() >= 0 && win == 1'(p)) && $urandom_range(0, 9) == 0) begin
              req[p] = 1'b0;
            end
          end else if ($urandom_range(0, 2) == 0) begin
            req[p] = 1'b1;
            we[p]  = 1'($urandom_range(0, 1));
            if (p == 0) begin
              addr0  = {12'($urandom), 8'($urandom_range(0, 15))};
              wdata0 = 16'($urandom);
            end else begin
              addr1  = {12'($urandom), 8'($urandom_range(0, 15))};
              wdata1 = 16'($urandom);
            end
          end
        end
      end
      // Only drop requests that are not mid-transaction.
      for (int c = 0; c < 40 && req != 2'b00; c++) begin
        @(posedge clk);
        #2;
        for (int p = 0; p < 2; p++) begin
          if (req[p] && !(phase() >= 0 && phase() < N && win == 1'(p))) req[p] = 1'b0;
        end
      end
      req = 2'b00;
      repeat (N + 4) @(negedge clk);
      fin = 1'b1;
    end
  end

  initial begin
    int   waited;
    logic both;
    waited = 0;
    both   = 1'b0;
    while (!both && waited < 20000) begin
      @(posedge clk);
      waited++;
      both = inst[0].fin && inst[1].fin;
    end
    check(9, "bench completion", 32'(both), 32'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
